// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder: 4-bit groups, 16-bit super-groups.
// One-cycle latency, with group propagate/generate and signed overflow flags.
module cla_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             grp_p,
    output logic             grp_g,
    output logic             ovf
);

    localparam int NG  = (WIDTH + 3) / 4;
    localparam int NSG = (NG + 3) / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("cla_adder: WIDTH must be a multiple of 4 in 4..64");
    end

    // Flattened 4-way lookahead; returns {c4, c3, c2, c1, c0} with c0 = cin.
    function automatic logic [4:0] la4(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       cin
    );
        logic [4:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic [NSG*4-1:0] w_gg;
    logic [NSG*4-1:0] w_gp;
    logic [NSG*4-1:0] w_gc;
    logic [NSG-1:0]   w_sgg;
    logic [NSG-1:0]   w_sgp;
    logic [NSG:0]     w_sc;
    logic [NSG:0]     w_sg;
    logic [4:0]       w_t;

    // Padding groups beyond NG pass carries straight through (GG=0, GP=1).
    always_comb begin
        w_g   = a & b;
        w_p   = a ^ b;
        w_gg  = '0;
        w_gp  = '1;
        w_gc  = '0;
        w_sgg = '0;
        w_sgp = '0;
        w_sc  = '0;
        w_sg  = '0;
        w_c   = '0;
        w_t   = '0;
        for (int k = 0; k < NG; k++) begin
            w_t     = la4(w_g[4*k +: 4], w_p[4*k +: 4], 1'b0);
            w_gg[k] = w_t[4];
            w_gp[k] = &w_p[4*k +: 4];
        end
        w_sc[0] = c_in;
        w_sg[0] = 1'b0;
        for (int j = 0; j < NSG; j++) begin
            w_t        = la4(w_gg[4*j +: 4], w_gp[4*j +: 4], 1'b0);
            w_sgg[j]   = w_t[4];
            w_sgp[j]   = &w_gp[4*j +: 4];
            w_sc[j+1]  = w_sgg[j] | (w_sgp[j] & w_sc[j]);
            w_sg[j+1]  = w_sgg[j] | (w_sgp[j] & w_sg[j]);
            w_t        = la4(w_gg[4*j +: 4], w_gp[4*j +: 4], w_sc[j]);
            w_gc[4*j +: 4] = w_t[3:0];
        end
        for (int k = 0; k < NG; k++) begin
            w_t = la4(w_g[4*k +: 4], w_p[4*k +: 4], w_gc[k]);
            w_c[4*k +: 4] = w_t[3:0];
        end
        w_c[WIDTH] = w_sc[NSG];
        w_s        = w_p ^ w_c[WIDTH-1:0];
    end

    logic             r_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_c_out;
    logic             r_grp_p;
    logic             r_grp_g;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_s     <= '0;
            r_c_out <= 1'b0;
            r_grp_p <= 1'b0;
            r_grp_g <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_s     <= w_s;
                r_c_out <= w_c[WIDTH];
                r_grp_p <= &w_p;
                r_grp_g <= w_sg[NSG];
                r_ovf   <= w_c[WIDTH-1] ^ w_c[WIDTH];
            end
        end
    end

    assign out_valid = r_valid;
    assign s         = r_s;
    assign c_out     = r_c_out;
    assign grp_p     = r_grp_p;
    assign grp_g     = r_grp_g;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_adder.sv
// Directed and random checks of cla_adder at WIDTH=4 and WIDTH=16.
module tb_cla_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        ci4 = 1'b0;
    logic        ov4, co4, gp4, gg4, of4;
    logic [3:0]  s4;
    logic        iv16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        ci16 = 1'b0;
    logic        ov16, co16, gp16, gg16, of16;
    logic [15:0] s16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cla_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4),
        .a(a4), .b(b4), .c_in(ci4),
        .out_valid(ov4), .s(s4), .c_out(co4),
        .grp_p(gp4), .grp_g(gg4), .ovf(of4)
    );

    cla_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16),
        .a(a16), .b(b16), .c_in(ci16),
        .out_valid(ov16), .s(s16), .c_out(co16),
        .grp_p(gp16), .grp_g(gg16), .ovf(of16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b,
                          input logic c);
        iv4 = 1'b1;
        a4  = a;
        b4  = b;
        ci4 = c;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv4 = 1'b1;
        a4  = 4'($urandom);
        b4  = 4'($urandom);
        ci4 = 1'($urandom);
        step();
        a4  = 4'($urandom);
        b4  = 4'($urandom);
        step();
        checks++; if (ov4 !== 1'b0) begin errors++;
            $display("FAIL rst_valid got=%b exp=0", ov4); end
        checks++; if (s4 !== 4'h0) begin errors++;
            $display("FAIL rst_s got=%h exp=0", s4); end
        checks++; if (co4 !== 1'b0) begin errors++;
            $display("FAIL rst_cout got=%b exp=0", co4); end
        checks++; if ({gp4, gg4, of4} !== 3'b000) begin errors++;
            $display("FAIL rst_flags got=%b exp=000", {gp4, gg4, of4}); end
        checks++; if ({ov16, s16} !== 17'h0) begin errors++;
            $display("FAIL rst_w16 got=%h exp=0", {ov16, s16}); end
    endtask

    task automatic test_basic();
        rst = 1'b0;
        drive4(4'b0101, 4'b0011, 1'b0);
        step();
        checks++; if (ov4 !== 1'b1) begin errors++;
            $display("FAIL basic_valid got=%b exp=1", ov4); end
        checks++; if (s4 !== 4'b1000) begin errors++;
            $display("FAIL basic_s got=%b exp=1000", s4); end
        checks++; if ({co4, of4} !== 2'b01) begin errors++;
            $display("FAIL basic_cout_ovf got=%b exp=01", {co4, of4}); end
        checks++; if ({gp4, gg4} !== 2'b00) begin errors++;
            $display("FAIL basic_pg got=%b exp=00", {gp4, gg4}); end
    endtask

    task automatic test_boundary();
        drive4(4'hF, 4'h0, 1'b1);
        step();
        drive4(4'hF, 4'hF, 1'b1);
        checks++; if ({ov4, co4, s4} !== 6'b11_0000) begin errors++;
            $display("FAIL wrap_sum got=%b exp=110000", {ov4, co4, s4}); end
        checks++; if ({gp4, gg4, of4} !== 3'b100) begin errors++;
            $display("FAIL wrap_flags got=%b exp=100", {gp4, gg4, of4}); end
        step();
        checks++; if ({ov4, co4, s4} !== 6'b11_1111) begin errors++;
            $display("FAIL ones_sum got=%b exp=111111", {ov4, co4, s4}); end
        checks++; if ({gp4, gg4, of4} !== 3'b010) begin errors++;
            $display("FAIL ones_flags got=%b exp=010", {gp4, gg4, of4}); end
    endtask

    task automatic test_hold();
        drive4(4'h2, 4'h1, 1'b0);
        step();
        checks++; if ({ov4, co4, s4} !== 6'b10_0011) begin errors++;
            $display("FAIL hold_load got=%b exp=100011", {ov4, co4, s4}); end
        iv4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a4  = (i == 0) ? 4'bxxxx : 4'(i * 5 + 3);
            b4  = 4'(15 - i);
            ci4 = 1'(i);
            step();
            checks++; if ({ov4, co4, s4} !== 6'b00_0011) begin errors++;
                $display("FAIL hold_%0d got=%b exp=000011", i, {ov4, co4, s4}); end
        end
    endtask

    task automatic test_reset_mid();
        drive4(4'h8, 4'h8, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        iv4 = 1'b0;
        checks++; if ({ov4, co4, of4, s4} !== 7'b0) begin errors++;
            $display("FAIL mid_rst got=%b exp=0000000", {ov4, co4, of4, s4}); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ea, eb;
        logic       ec;
        logic [4:0] sum;
        logic       eo;
        ea = 4'($urandom);
        eb = 4'($urandom);
        ec = 1'($urandom);
        drive4(ea, eb, ec);
        for (int i = 0; i < 20; i++) begin
            step();
            sum = {1'b0, ea} + {1'b0, eb} + {4'b0, ec};
            eo  = (ea[3] == eb[3]) && (sum[3] != ea[3]);
            checks++; if ({ov4, co4, s4} !== {1'b1, sum}) begin errors++;
                $display("FAIL b2b_%0d got=%b exp=%b a=%h b=%h c=%b",
                         i, {ov4, co4, s4}, {1'b1, sum}, ea, eb, ec); end
            checks++; if (of4 !== eo) begin errors++;
                $display("FAIL b2b_ovf_%0d got=%b exp=%b", i, of4, eo); end
            ea = 4'($urandom);
            eb = 4'($urandom);
            ec = 1'($urandom);
            drive4(ea, eb, ec);
        end
        iv4 = 1'b0;
    endtask

    task automatic test_w16();
        iv16 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'h0001; ci16 = 1'b0;
        step();
        a16 = 16'h7FFF; b16 = 16'h0001; ci16 = 1'b0;
        checks++; if ({ov16, co16, of16, s16} !== {3'b110, 16'h0000}) begin
            errors++;
            $display("FAIL w16_wrap got=%b %b %b %h exp=1 1 0 0000",
                     ov16, co16, of16, s16); end
        step();
        a16 = 16'h1234; b16 = 16'h4321; ci16 = 1'b1;
        checks++; if ({ov16, co16, of16, s16} !== {3'b101, 16'h8000}) begin
            errors++;
            $display("FAIL w16_ovf got=%b %b %b %h exp=1 0 1 8000",
                     ov16, co16, of16, s16); end
        step();
        a16 = 16'hF0F0; b16 = 16'h0F0F; ci16 = 1'b1;
        checks++; if ({co16, of16, s16} !== {2'b00, 16'h5556}) begin
            errors++;
            $display("FAIL w16_mix got=%b %b %h exp=0 0 5556",
                     co16, of16, s16); end
        step();
        iv16 = 1'b0;
        checks++; if ({co16, gp16, gg16, s16} !== {3'b110, 16'h0000}) begin
            errors++;
            $display("FAIL w16_prop got=%b %b %b %h exp=1 1 0 0000",
                     co16, gp16, gg16, s16); end
        step();
        checks++; if ({ov16, s16} !== {1'b0, 16'h0000}) begin errors++;
            $display("FAIL w16_idle got=%b %h exp=0 0000", ov16, s16); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_w16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
